// File: rtl/fp_divider.sv
// Sequential FP32 divider: quotient = num1 / num2.
// A restoring divider produces one quotient bit per clock. Operands and the
// result each travel over a valid/ready handshake. Special operands bypass
// the divider and go straight to DONE.
module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        out_valid,
  input  logic        out_ready
);

  // 24 significand bits + 1 normalisation bit + 1 guard bit
  localparam int ITER = 26;
  localparam logic [4:0] LAST_COUNT = 5'(ITER - 1);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        sign_reg;
  logic [7:0]  ea_reg, eb_reg;
  logic [23:0] mb_reg;
  logic [24:0] rem_reg;
  logic [25:0] q_reg;
  logic [4:0]  count_reg;
  logic [31:0] quotient_reg;
  logic        dbz_reg;
  logic        out_valid_reg;

  logic        accept;
  logic        fire;

  // operand fields as presented on the input ports
  logic        sign_in;
  logic [7:0]  ea_in, eb_in;

  // special-case decode
  logic        special;
  logic [31:0] spec_q;
  logic        spec_dbz;

  // restoring divide step
  logic        ge;
  logic [23:0] rem_diff;
  logic [23:0] rem_keep;
  logic [24:0] rem_step;
  logic [25:0] q_step;

  // normalise / round
  logic [22:0]        sig;
  logic               guard;
  logic [23:0]        sig_round;
  logic               carry;
  logic signed [9:0]  ea_ext, eb_ext, bias, carry_ext, e_norm;
  logic [31:0]        norm_q;

  assign in_ready    = (state_reg == IDLE);
  assign accept      = in_valid && (state_reg == IDLE);
  assign fire        = out_valid_reg && out_ready;
  assign quotient    = quotient_reg;
  assign div_by_zero = dbz_reg;
  assign out_valid   = out_valid_reg;

  assign sign_in = num1[31] ^ num2[31];
  assign ea_in   = num1[30:23];
  assign eb_in   = num2[30:23];

  // Special operands, checked in priority order; exponent 0 is treated as zero
  always_comb begin
    special  = 1'b1;
    spec_q   = 32'h0;
    spec_dbz = 1'b0;
    if (ea_in == 8'h00 && eb_in == 8'h00) begin
      spec_q = QNAN;
    end else if (ea_in == 8'hFF && eb_in == 8'hFF) begin
      spec_q = QNAN;
    end else if (ea_in == 8'h00) begin
      spec_q = {sign_in, 31'b0};
    end else if (eb_in == 8'h00) begin
      spec_q   = {sign_in, 8'hFF, 23'b0};
      spec_dbz = 1'b1;
    end else if (ea_in == 8'hFF) begin
      spec_q = {sign_in, 8'hFF, 23'b0};
    end else if (eb_in == 8'hFF) begin
      spec_q = {sign_in, 31'b0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step. After a subtraction the remainder is below mb, so the
  // low 24 bits of the difference are exact and the shift never overflows.
  always_comb begin
    ge       = (rem_reg >= {1'b0, mb_reg});
    rem_diff = rem_reg[23:0] - mb_reg;
    rem_keep = ge ? rem_diff : rem_reg[23:0];
    rem_step = {rem_keep, 1'b0};
    q_step   = {q_reg[24:0], ge};
  end

  // Normalise on q[25], round half-up with the guard bit, then range-check.
  // Rounding the 23-bit fraction alone: a carry into bit 23 is exactly the
  // overflow of {1,fraction}, and leaves the fraction bits at zero.
  always_comb begin
    sig       = q_reg[25] ? q_reg[24:2] : q_reg[23:1];
    guard     = q_reg[25] ? q_reg[1]    : q_reg[0];
    sig_round = {1'b0, sig} + {23'b0, guard};
    carry     = sig_round[23];
    ea_ext    = {2'b00, ea_reg};
    eb_ext    = {2'b00, eb_reg};
    bias      = q_reg[25] ? 10'sd127 : 10'sd126;
    carry_ext = {9'b0, carry};
    e_norm    = ea_ext - eb_ext + bias + carry_ext;
    if (e_norm <= 10'sd0) begin
      norm_q = {sign_reg, 31'b0};
    end else if (e_norm >= 10'sd255) begin
      norm_q = {sign_reg, 8'hFF, 23'b0};
    end else begin
      norm_q = {sign_reg, e_norm[7:0], sig_round[22:0]};
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : DIVIDE;
      DIVIDE:  if (count_reg == LAST_COUNT) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    if (fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand capture, divider iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg     <= 1'b0;
      ea_reg       <= 8'h0;
      eb_reg       <= 8'h0;
      mb_reg       <= 24'h0;
      rem_reg      <= 25'h0;
      q_reg        <= 26'h0;
      count_reg    <= 5'h0;
      quotient_reg <= 32'h0;
      dbz_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg  <= sign_in;
            ea_reg    <= ea_in;
            eb_reg    <= eb_in;
            mb_reg    <= {1'b1, num2[22:0]};
            rem_reg   <= {2'b01, num1[22:0]};
            q_reg     <= 26'h0;
            count_reg <= 5'h0;
            if (special) begin
              quotient_reg <= spec_q;
              dbz_reg      <= spec_dbz;
            end else begin
              dbz_reg      <= 1'b0;
            end
          end
        end
        DIVIDE: begin
          rem_reg   <= rem_step;
          q_reg     <= q_step;
          count_reg <= count_reg + 5'd1;
        end
        NORM: quotient_reg <= norm_q;
        default: ;
      endcase
    end
  end

  // out_valid follows DONE by one edge and drops on the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid_reg <= 1'b0;
    else        out_valid_reg <= (state_reg == DONE) && !fire;
  end

endmodule
